config_reg_bank: RTL and testbench

//  Parametrised, double-buffered configuration register bank for the trigger board.
//  It sits between the command decoder (write/read strobes) and the trigger logic, which reads the flat active-register bus.

---
 rtl/config_reg_pkg.sv | 21 ++
 rtl/cfg_shadow_cell.sv | 23 ++
 rtl/config_reg_bank.sv | 81 ++++++++
 tb/tb_config_reg_bank.sv | 137 +++++++++++++
 4 files changed

// File: rtl/config_reg_pkg.sv
// config_reg_pkg: address map, command bit names and reset values for config_reg_bank.
package config_reg_pkg;
  localparam int ADDR_CTRL = 0;
  localparam int ADDR_CMD = 1;
  localparam int ADDR_LOCK = 2;
  localparam int ADDR_FIRST_SHADOW = 3;
  localparam int CMD_COMMIT = 0;
  localparam int CMD_CYC_TRG_BGN = 5;
  localparam int CMD_RST = 6;
  localparam int CFG_TBL_LEN = 32;
  // CMD and LOCK are not stored, so their slots stay zero
  localparam logic [15:0] CFG_RST_VAL [CFG_TBL_LEN] = '{
    16'h0001, 16'h0000, 16'h0000, 16'h0100, 16'h0203, 16'h0304, 16'h0405, 16'h0506,
    16'h0607, 16'h0708, 16'h0809, 16'h090A, 16'h0A0B, 16'h0B0C, 16'h0C0D, 16'h0D0E,
    16'h0E0F, 16'h0F10, 16'h1011, 16'h1112, 16'h1213, 16'h1314, 16'h1415, 16'h1516,
    16'h1617, 16'h1718, 16'h1819, 16'h191A, 16'h1A1B, 16'h1B1C, 16'h1C1D, 16'hBEEF
  };
  function automatic logic [15:0] cfg_rst_val(input int i);
    return (i < CFG_TBL_LEN) ? CFG_RST_VAL[i] : 16'h0000;
  endfunction
endpackage

// File: rtl/cfg_shadow_cell.sv
// cfg_shadow_cell: one shadow/active register pair; commit copies the pre-edge shadow.
module cfg_shadow_cell #(
  parameter int DATA_W = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] rst_val,
  input  logic              we,
  input  logic              commit,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] active
);
  logic [DATA_W-1:0] shadow;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shadow <= rst_val;
      active <= rst_val;
    end else begin
      shadow <= we ? data_in : shadow;
      active <= commit ? shadow : active;
    end
  end
endmodule

// File: rtl/config_reg_bank.sv
// config_reg_bank: double-buffered config bank with lock, readback, command pulses and write counter.
module config_reg_bank
  import config_reg_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter logic [DATA_W-1:0] LOCK_KEY = DATA_W'(16'hA5C3)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       wr_in,
  input  logic [ADDR_W-1:0]          wr_addr_in,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       rd_in,
  input  logic [ADDR_W-1:0]          rd_addr_in,
  input  logic                       commit_in,
  output logic [DATA_W-1:0]          rd_data_out,
  output logic                       rd_valid_out,
  output logic [NUM_REGS*DATA_W-1:0] cfg_flat_out,
  output logic [DATA_W-1:0]          cmd_pulse_out,
  output logic                       pending_out,
  output logic                       locked_out,
  output logic                       wr_err_out,
  output logic [15:0]                config_received_out
);
  localparam int IW = $clog2(NUM_REGS);
  logic [DATA_W-1:0] act [NUM_REGS];
  logic [DATA_W-1:0] ctrl, rd_mux;
  logic acc, is_cmd, is_shadow, commit;
  int wa, ra;
  assign wa = int'(wr_addr_in);
  assign ra = int'(rd_addr_in);
  assign acc = wr_in && wa < NUM_REGS && !(locked_out && wa >= ADDR_FIRST_SHADOW);
  assign is_cmd = acc && wa == ADDR_CMD;
  assign is_shadow = acc && wa >= ADDR_FIRST_SHADOW;
  assign commit = commit_in || (is_cmd && data_in[CMD_COMMIT]);
  assign act[ADDR_CTRL] = ctrl;
  assign act[ADDR_CMD] = '0;
  assign act[ADDR_LOCK] = '0;
  for (genvar i = ADDR_FIRST_SHADOW; i < NUM_REGS; i++) begin : g_cell
    cfg_shadow_cell #(.DATA_W(DATA_W)) u_cell (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rst_val(DATA_W'(cfg_rst_val(i))),
      .we     (is_shadow && wa == i),
      .commit (commit && pending_out),
      .data_in(data_in),
      .active (act[i])
    );
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign cfg_flat_out[i*DATA_W +: DATA_W] = act[i];
  end
  always_comb begin
    rd_mux = '0;
    rd_mux = ra == ADDR_LOCK ? DATA_W'(locked_out) : ra < NUM_REGS ? act[rd_addr_in[IW-1:0]] : '0;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ctrl <= DATA_W'(cfg_rst_val(ADDR_CTRL));
      locked_out <= 1'b1;
      pending_out <= 1'b0;
      cmd_pulse_out <= '0;
      wr_err_out <= 1'b0;
      rd_valid_out <= 1'b0;
      rd_data_out <= '0;
      config_received_out <= '0;
    end else begin
      ctrl <= (acc && wa == ADDR_CTRL) ? data_in : ctrl;
      locked_out <= (acc && wa == ADDR_LOCK) ? data_in != LOCK_KEY : locked_out;
      pending_out <= is_shadow ? 1'b1 : commit ? 1'b0 : pending_out;
      cmd_pulse_out <= is_cmd ? data_in : '0;
      wr_err_out <= wr_in && !acc;
      rd_valid_out <= rd_in;
      rd_data_out <= rd_in ? rd_mux : rd_data_out;
      config_received_out <= (acc && config_received_out != 16'hFFFF) ? config_received_out + 16'd1
                                                                        : config_received_out;
    end
  end
endmodule

// File: tb/tb_config_reg_bank.sv
// tb_config_reg_bank: random and directed stimulus checked against a transaction-level model.
module tb_config_reg_bank;
  import config_reg_pkg::*;
  localparam int N = 32;
  localparam int W = 16;
  localparam logic [15:0] KEY = 16'hA5C3;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0, wr_in = 1'b0, rd_in = 1'b0, commit_in = 1'b0;
  logic [7:0] wr_addr_in = '0, rd_addr_in = '0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] rd_data_out, cmd_pulse_out;
  logic rd_valid_out, pending_out, locked_out, wr_err_out;
  logic [N*W-1:0] cfg_flat_out;
  logic [15:0] config_received_out;
  int checks = 0, errors = 0;
  logic [15:0] m_act [N], m_sh [N];
  logic m_locked, m_pend, m_rdv, m_err;
  logic [15:0] m_rdd, m_cmd, m_cnt;

  config_reg_bank dut (
    .clk_in(clk_in), .rst_in(rst_in), .wr_in(wr_in), .wr_addr_in(wr_addr_in),
    .data_in(data_in), .rd_in(rd_in), .rd_addr_in(rd_addr_in), .commit_in(commit_in),
    .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out), .cfg_flat_out(cfg_flat_out),
    .cmd_pulse_out(cmd_pulse_out), .pending_out(pending_out), .locked_out(locked_out),
    .wr_err_out(wr_err_out), .config_received_out(config_received_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic r, w, input int wa, input logic [15:0] d,
                       input logic rd, input int ra, input logic cm);
    logic ok, cmt;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_act[i] = cfg_rst_val(i);
        m_sh[i] = cfg_rst_val(i);
      end
      {m_locked, m_pend, m_rdv, m_err, m_rdd, m_cmd, m_cnt} = {1'b1, 3'b0, 48'h0};
      return;
    end
    ok = w && wa < N && !(m_locked && wa >= 3);
    m_rdv = rd;
    if (rd) m_rdd = (ra == 2) ? {15'h0, m_locked} : (ra < N && ra != 1) ? m_act[ra] : 16'h0;
    cmt = cm || (ok && wa == 1 && d[0]);
    if (cmt && m_pend) for (int i = 3; i < N; i++) m_act[i] = m_sh[i];
    m_pend = (ok && wa >= 3) ? 1'b1 : cmt ? 1'b0 : m_pend;
    if (ok && wa == 0) m_act[0] = d;
    if (ok && wa == 2) m_locked = (d != KEY);
    if (ok && wa >= 3) m_sh[wa] = d;
    m_cmd = (ok && wa == 1) ? d : 16'h0;
    m_err = w && !ok;
    if (ok && m_cnt != 16'hFFFF) m_cnt++;
  endtask

  task automatic step(input logic r, w, input int wa, input logic [15:0] d,
                      input logic rd, input int ra, input logic cm);
    @(negedge clk_in);
    rst_in = r; wr_in = w; wr_addr_in = 8'(wa); data_in = d;
    rd_in = rd; rd_addr_in = 8'(ra); commit_in = cm;
    model(r, w, wa, d, rd, ra, cm);
    @(posedge clk_in);
    #1;
    chk("rd_valid", 32'(rd_valid_out), 32'(m_rdv));
    chk($sformatf("rd_data@%0d", ra), 32'(rd_data_out), 32'(m_rdd));
    chk("cmd_pulse", 32'(cmd_pulse_out), 32'(m_cmd));
    chk("wr_err", 32'(wr_err_out), 32'(m_err));
    chk("pending", 32'(pending_out), 32'(m_pend));
    chk("locked", 32'(locked_out), 32'(m_locked));
    chk("count", 32'(config_received_out), 32'(m_cnt));
    for (int i = 0; i < N; i++) chk($sformatf("flat%0d", i), 32'(cfg_flat_out[i*W +: W]), 32'(m_act[i]));
  endtask

  task automatic wr(input int a, input logic [15:0] d, input logic cm = 1'b0);
    step(1'b0, 1'b1, a, d, 1'b0, 0, cm);
  endtask

  task automatic rdr(input int a);
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, a, 1'b0);
  endtask

  initial begin
    step(1'b1, 1'b0, 0, 16'h0, 1'b0, 0, 1'b0);
    for (int a = 0; a < N + 2; a++) rdr(a);
    rdr(255);
    wr(5, 16'h1234);
    chk("locked_rej_count", 32'(config_received_out), 32'h0);
    wr(2, KEY);
    wr(5, 16'h1234);
    rdr(5);
    step(1'b0, 1'b0, 0, 16'h0, 1'b0, 0, 1'b1);
    rdr(5);
    chk("commit_reg5", 32'(cfg_flat_out[5*W +: W]), 32'h1234);
    wr(5, 16'h5678, 1'b1);
    rdr(5);
    step(1'b0, 1'b1, 7, 16'h0BAD, 1'b1, 7, 1'b0);
    wr(1, 16'h0061);
    chk("cmd_61", 32'(cmd_pulse_out), 32'h0061);
    rdr(1);
    @(negedge clk_in);
    force dut.config_received_out = 16'hFFFC;
    #1 release dut.config_received_out;
    m_cnt = 16'hFFFC;
    wr(0, 16'hAAAA);
    wr(0, 16'h5555);
    chk("cnt_fffe", 32'(config_received_out), 32'hFFFE);
    wr(3, 16'h0303);
    wr(4, 16'h0404);
    wr(6, 16'h0606);
    chk("cnt_sat", 32'(config_received_out), 32'hFFFF);
    wr(N, 16'h1111);
    wr(9, 16'h9999);
    step(1'b1, 1'b0, 0, 16'h0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 16'h0, 1'b0, 0, 1'b1);
    wr(2, KEY);
    step(1'b1, 1'b1, 1, 16'hFFFF, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, 2, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      int wa, ra;
      logic [15:0] d;
      wa = ($urandom % 8 == 0) ? int'($urandom % 256) : int'($urandom % (N + 2));
      ra = ($urandom % 8 == 0) ? int'($urandom % 256) : int'($urandom % (N + 2));
      d = 16'($urandom);
      if (wa == 2 && $urandom % 3 != 0) d = KEY;
      step($urandom % 250 == 0, 1'($urandom), wa, d, 1'($urandom), ra, $urandom % 6 == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
